// File: rtl/brush_tool_pkg.sv
// Shared colour definitions and sizing helper for the brush stamping block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package brush_tool_pkg;

  localparam int COLOR_WIDTH = 3;

  typedef logic [COLOR_WIDTH-1:0] color_t;

  localparam color_t COLOR_NONE  = 3'b000;
  localparam color_t COLOR_BLUE  = 3'b001;
  localparam color_t COLOR_GREEN = 3'b010;
  localparam color_t COLOR_RED   = 3'b100;
  localparam color_t COLOR_WHITE = 3'b111;

  // Requested edge length to the one actually stamped: 0 means a single pixel.
  function automatic int clamp_size(input int req, input int max_size);
    if (req < 1) return 1;
    if (req > max_size) return max_size;
    return req;
  endfunction

endpackage

// File: rtl/brush_scan_counter.sv
// Raster offset counter for a square stamp: dx fastest, then dy, with last-offset flag.
// Latency: offset advances one step per cycle with step asserted; clear takes effect on the next edge.
// Backpressure: none; the owner gates step.
module brush_scan_counter #(
  parameter  int MAX_SIZE = 8,
  localparam int SW       = $clog2(MAX_SIZE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [SW-1:0] size,
  output logic [SW-1:0] nxt_dx,
  output logic [SW-1:0] nxt_dy,
  output logic          last
);

  logic [SW-1:0] dx;
  logic [SW-1:0] dy;
  logic          x_end;
  logic          y_end;

  always_comb begin
    x_end  = (dx == size - SW'(1));
    y_end  = (dy == size - SW'(1));
    last   = x_end && y_end;
    nxt_dx = x_end ? '0 : dx + SW'(1);
    nxt_dy = x_end ? dy + SW'(1) : dy;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      dx <= nxt_dx;
      dy <= nxt_dy;
    end
  end

endmodule

// File: rtl/brush_tool.sv
// Stamps a clipped square brush as a stream of pixel writes, one offset per cycle.
// Latency: first pixel one cycle after accept; done pulses S*S+1 cycles after accept.
// Backpressure: none; start is only sampled in IDLE and ignored otherwise.
module brush_tool
  import brush_tool_pkg::*;
#(
  parameter  int WIDTH    = 640,
  parameter  int HEIGHT   = 480,
  parameter  int MAX_SIZE = 8,
  localparam int XW       = $clog2(WIDTH),
  localparam int YW       = $clog2(HEIGHT),
  localparam int SW       = $clog2(MAX_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   erase,
  input  logic [XW-1:0]          cursor_x,
  input  logic [YW-1:0]          cursor_y,
  input  logic [SW-1:0]          brush_size,
  input  logic [COLOR_WIDTH-1:0] input_color,
  output logic [XW-1:0]          pixel_x,
  output logic [YW-1:0]          pixel_y,
  output logic [COLOR_WIDTH-1:0] pixel_color,
  output logic                   pixel_valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [XW-1:0] x0_q;
  logic [YW-1:0] y0_q;
  logic [SW-1:0] size_q;
  color_t        color_q;

  logic          accept;
  logic          step;
  logic          last;
  logic [SW-1:0] nxt_dx;
  logic [SW-1:0] nxt_dy;

  logic [SW-1:0] size_eff;
  color_t        color_sel;
  logic [XW-1:0] base_x;
  logic [YW-1:0] base_y;
  logic [SW-1:0] off_x;
  logic [SW-1:0] off_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          on_screen;

  logic [XW-1:0] pixel_x_nxt;
  logic [YW-1:0] pixel_y_nxt;
  color_t        pixel_color_nxt;
  logic          pixel_valid_nxt;
  logic          busy_nxt;
  logic          done_nxt;

  brush_scan_counter #(
    .MAX_SIZE(MAX_SIZE)
  ) u_scan (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .step   (step),
    .size   (size_q),
    .nxt_dx (nxt_dx),
    .nxt_dy (nxt_dy),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (last) state_nxt = ST_DONE;
        else      step      = 1'b1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output registers are loaded with the pixel being entered, so on accept
  // the live cursor/colour are used directly with offset (0,0).
  always_comb begin
    size_eff  = SW'(clamp_size(int'(brush_size), MAX_SIZE));
    color_sel = accept ? (erase ? COLOR_NONE : input_color) : color_q;
    base_x    = accept ? cursor_x : x0_q;
    base_y    = accept ? cursor_y : y0_q;
    off_x     = accept ? '0 : nxt_dx;
    off_y     = accept ? '0 : nxt_dy;
    sum_x     = {1'b0, base_x} + (XW+1)'(off_x);
    sum_y     = {1'b0, base_y} + (YW+1)'(off_y);
    on_screen = (sum_x < (XW+1)'(WIDTH)) && (sum_y < (YW+1)'(HEIGHT));

    pixel_valid_nxt = (accept || step) && on_screen;
    pixel_x_nxt     = pixel_valid_nxt ? sum_x[XW-1:0] : pixel_x;
    pixel_y_nxt     = pixel_valid_nxt ? sum_y[YW-1:0] : pixel_y;
    pixel_color_nxt = pixel_valid_nxt ? color_sel : COLOR_NONE;
    busy_nxt        = (state_nxt == ST_DRAW);
    done_nxt        = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q        <= '0;
      y0_q        <= '0;
      size_q      <= '0;
      color_q     <= COLOR_NONE;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= COLOR_NONE;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (accept) begin
        x0_q    <= cursor_x;
        y0_q    <= cursor_y;
        size_q  <= size_eff;
        color_q <= color_sel;
      end
      pixel_x     <= pixel_x_nxt;
      pixel_y     <= pixel_y_nxt;
      pixel_color <= pixel_color_nxt;
      pixel_valid <= pixel_valid_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_brush_tool.sv
// Randomised self-checking bench for brush_tool on an 8x8 screen with MAX_SIZE=4.
module tb_brush_tool;
  import brush_tool_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       erase;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic [2:0] brush_size;
  color_t     input_color;
  logic [2:0] pixel_x;
  logic [2:0] pixel_y;
  color_t     pixel_color;
  logic       pixel_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  // Model of the last position written; x/y hold it whenever nothing is written.
  int exp_x  = 0;
  int exp_y  = 0;

  brush_tool #(.WIDTH(W), .HEIGHT(H), .MAX_SIZE(M)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .erase       (erase),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .brush_size  (brush_size),
    .input_color (input_color),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_color (pixel_color),
    .pixel_valid (pixel_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Observation packing everywhere: {busy, done, valid, x, y, color}.
  task automatic run_stamp(input logic [2:0] x, input logic [2:0] y, input logic [2:0] bs,
                           input color_t col, input logic er, input bit hold_start,
                           input string name);
    int s;
    color_t c;
    logic [11:0] obs;
    logic [11:0] want;
    s = (bs == 3'd0) ? 1 : ((int'(bs) > M) ? M : int'(bs));
    c = er ? COLOR_NONE : col;

    @(negedge clk);
    obs  = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
    want = {3'b000, 3'(exp_x), 3'(exp_y), COLOR_NONE};
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s idle: got %h want %h", name, obs, want);
    end
    start       = 1'b1;
    cursor_x    = x;
    cursor_y    = y;
    brush_size  = bs;
    input_color = col;
    erase       = er;

    for (int dy = 0; dy < s; dy++) begin
      for (int dx = 0; dx < s; dx++) begin
        @(negedge clk);
        if (int'(x) + dx < W && int'(y) + dy < H) begin
          exp_x = int'(x) + dx;
          exp_y = int'(y) + dy;
          want  = {3'b101, 3'(exp_x), 3'(exp_y), c};
        end else begin
          want  = {3'b100, 3'(exp_x), 3'(exp_y), COLOR_NONE};
        end
        obs = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
        checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL %s draw dx=%0d dy=%0d: got %h want %h", name, dx, dy, obs, want);
        end
        // Inputs scrambled mid-stamp must not disturb it.
        start       = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
        cursor_x    = 3'($urandom);
        cursor_y    = 3'($urandom);
        brush_size  = 3'($urandom);
        input_color = 3'($urandom);
        erase       = 1'($urandom);
      end
    end

    @(negedge clk);
    obs  = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
    want = {3'b010, 3'(exp_x), 3'(exp_y), COLOR_NONE};
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s done: got %h want %h", name, obs, want);
    end
    start = hold_start;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    reset       = 1'b1;
    start       = 1'b1;
    erase       = 1'b0;
    cursor_x    = 3'd5;
    cursor_y    = 3'd2;
    brush_size  = 3'd2;
    input_color = COLOR_RED;
    repeat (3) @(negedge clk);
    obs = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", obs, 12'h000);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    obs = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, 12'h000);
    end
    exp_x = 0;
    exp_y = 0;
  endtask

  task automatic test_basic();
    run_stamp(3'd1, 3'd1, 3'd2, COLOR_BLUE, 1'b0, 1'b0, "size2_blue");
  endtask

  task automatic test_clip();
    run_stamp(3'd6, 3'd6, 3'd3, COLOR_RED, 1'b0, 1'b0, "clip_corner");
    run_stamp(3'd7, 3'd0, 3'd4, COLOR_WHITE, 1'b0, 1'b0, "clip_right");
  endtask

  task automatic test_size_clamp();
    run_stamp(3'd3, 3'd4, 3'd0, COLOR_GREEN, 1'b0, 1'b0, "size0");
    run_stamp(3'd2, 3'd1, 3'd7, COLOR_BLUE, 1'b0, 1'b0, "size7");
    run_stamp(3'd0, 3'd0, 3'd5, COLOR_RED, 1'b0, 1'b0, "size5");
  endtask

  task automatic test_erase();
    run_stamp(3'd4, 3'd5, 3'd1, COLOR_GREEN, 1'b1, 1'b0, "erase");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++)
      run_stamp(3'($urandom), 3'($urandom), 3'd1, COLOR_RED, 1'b0, 1'b1, "b2b");
    run_stamp(3'd2, 3'd2, 3'd2, COLOR_GREEN, 1'b0, 1'b0, "b2b_tail");
  endtask

  task automatic test_reset_mid_draw();
    logic [11:0] obs;
    logic        seen_bad;
    @(negedge clk);
    start       = 1'b1;
    erase       = 1'b0;
    cursor_x    = 3'd1;
    cursor_y    = 3'd2;
    brush_size  = 3'd4;
    input_color = COLOR_WHITE;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    obs = {busy, done, pixel_valid, pixel_x, pixel_y, pixel_color};
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL abort_reset: got %h want %h", obs, 12'h000);
    end
    reset = 1'b0;
    start = 1'b0;
    exp_x = 0;
    exp_y = 0;
    seen_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || pixel_valid) seen_bad = 1'b1;
    end
    checks++;
    if (seen_bad !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got activity=%b want 0", seen_bad);
    end
    run_stamp(3'd5, 3'd3, 3'd2, COLOR_BLUE, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_stamp(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                1'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), "random");
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_size_clamp();
    test_erase();
    test_back_to_back();
    test_reset_mid_draw();
    test_random();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brush_tool.md
BRUSH_TOOL -- requirements
Module: brush_tool

Interface
REQ-001 Parameter WIDTH, default 640: screen width in pixels.
REQ-002 Parameter HEIGHT, default 480: screen height in pixels.
REQ-003 Parameter MAX_SIZE, default 8: largest brush edge length in pixels, at least 1.
REQ-004 Port clk  input  1  clock; all logic on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  request for one brush stamp; sampled only in IDLE.
REQ-007 Port erase  input  1  when 1 at accept, stamp colour is COLOR_NONE.
REQ-008 Port cursor_x  input  $clog2(WIDTH)  stamp top-left x.
REQ-009 Port cursor_y  input  $clog2(HEIGHT)  stamp top-left y.
REQ-010 Port brush_size  input  $clog2(MAX_SIZE+1)  square edge length.
REQ-011 Port input_color  input  COLOR_WIDTH  stamp colour.
REQ-012 Port pixel_x  output  $clog2(WIDTH)  current pixel x.
REQ-013 Port pixel_y  output  $clog2(HEIGHT)  current pixel y.
REQ-014 Port pixel_color  output  COLOR_WIDTH  current pixel colour.
REQ-015 Port pixel_valid  output  1  current pixel is to be written.
REQ-016 Port busy  output  1  high in DRAW.
REQ-017 Port done  output  1  one-cycle pulse in DONE.

Function
REQ-018 FSM states SHALL be IDLE, DRAW and DONE, with IDLE->DRAW on start, DRAW->DONE after the last offset, and DONE->IDLE unconditionally.
REQ-019 On the clock edge that accepts start in IDLE, the block SHALL latch cursor_x, cursor_y, the effective size, and the colour (COLOR_NONE if erase, else input_color).
REQ-020 Effective size SHALL be 1 when brush_size is 0, MAX_SIZE when brush_size exceeds MAX_SIZE, and brush_size otherwise.
REQ-021 DRAW SHALL last exactly S*S cycles for effective size S, visiting offsets (dx,dy) in raster order: dx 0..S-1 fastest, then dy 0..S-1.
REQ-022 Each DRAW cycle SHALL present pixel_x=x0+dx and pixel_y=y0+dy, with the addition carried at one bit wider than the output width.
REQ-023 pixel_valid SHALL be 1 only when x0+dx<WIDTH and y0+dy<HEIGHT; off-screen offsets are still stepped (timing fixed, no wrap-around).
REQ-024 Outside DRAW or when pixel_valid=0, pixel_color SHALL be COLOR_NONE and pixel_x/pixel_y SHALL hold their last values.
REQ-025 The first pixel SHALL appear in the cycle after accept, and done SHALL be high in cycle S*S+1 after accept.
REQ-026 start during DRAW or DONE SHALL be ignored, with no queuing; start in the first IDLE cycle after DONE SHALL be accepted.
REQ-027 Input changes during DRAW SHALL NOT affect the stamp in progress.
REQ-028 busy and done SHALL never be high together.

Reset
REQ-029 Reset SHALL force state IDLE, pixel_x=0, pixel_y=0, pixel_color=COLOR_NONE, and pixel_valid=busy=done=0, with the offset counters cleared.
REQ-030 Reset asserted mid-DRAW SHALL abort the stamp on that edge: no further valid pixels and no done pulse.
REQ-031 Reset SHALL take priority over start in the same cycle.

Structure
REQ-032 COLOR_WIDTH, COLOR_NONE and the colour constants SHALL come from the shared common package; the FSM state enum is local to the module.
REQ-033 The dx/dy raster counter, with a last-offset flag, SHALL be one sub-module, brush_scan_counter, parametrised by MAX_SIZE.
REQ-034 The block SHALL use no memories, and all outputs SHALL be registered.

Verification (WIDTH=8, HEIGHT=8, MAX_SIZE=4, COLOR_WIDTH per package)
REQ-035 Size 2 at (1,1), blue, start held 1 cycle -> pixels (1,1),(2,1),(1,2),(2,2) valid and blue in cycles 1-4, done in cycle 5, then IDLE.
REQ-036 Size 3 at (6,6) -> 9 DRAW cycles; valid only at (6,6),(7,6),(6,7),(7,7); done in cycle 10.
REQ-037 brush_size=0 -> single pixel at the cursor; brush_size=7 -> clamped to 4, giving 16 DRAW cycles.
REQ-038 erase=1 with input_color=green, size 1 -> one pixel with pixel_color=COLOR_NONE and pixel_valid=1.
REQ-039 start held high continuously with size 1 -> accepts every 3 cycles (DRAW, DONE, IDLE); cursor changed mid-DRAW is ignored.
REQ-040 Reset in the 3rd DRAW cycle of a size-4 stamp -> next cycle shows all reset values, no done, and a new start is then accepted normally.
